// File: rtl/decode_issue.sv
// In-order RV64I decode/issue stage: latches one instruction from fetch, stalls on
// scoreboard hazards, reads operands from the registered register file and issues.
module decode_issue (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ifetch_valid,
  input  logic [31:0] ifetch_instr,
  input  logic [63:0] ifetch_pc,
  output logic        ofetch_ready,
  output logic [4:0]  orf_read_reg_num0,
  output logic [4:0]  orf_read_reg_num1,
  input  logic [63:0] irf_read_data0,
  input  logic [63:0] irf_read_data1,
  input  logic        iwb_valid,
  input  logic [4:0]  iwb_reg_num,
  input  logic        iflush,
  output logic        oex_valid,
  input  logic        iex_ready,
  output logic [63:0] oex_pc,
  output logic [6:0]  oex_opcode,
  output logic [2:0]  oex_funct3,
  output logic [6:0]  oex_funct7,
  output logic [4:0]  oex_rd,
  output logic [63:0] oex_rs1_data,
  output logic [63:0] oex_rs2_data,
  output logic [63:0] oex_imm
);

  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_AUIPC     = 7'h17;
  localparam logic [6:0] OPC_JAL       = 7'h6F;
  localparam logic [6:0] OPC_JALR      = 7'h67;
  localparam logic [6:0] OPC_BRANCH    = 7'h63;
  localparam logic [6:0] OPC_LOAD      = 7'h03;
  localparam logic [6:0] OPC_STORE     = 7'h23;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] OPC_OP_32     = 7'h3B;
  localparam logic [6:0] OPC_FENCE     = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM    = 7'h73;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_ISSUE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] busy_q, busy_d;

  logic [63:0] ex_pc_q, ex_pc_d;
  logic [6:0]  ex_opcode_q, ex_opcode_d;
  logic [2:0]  ex_funct3_q, ex_funct3_d;
  logic [6:0]  ex_funct7_q, ex_funct7_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic [63:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [63:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [63:0] ex_imm_q, ex_imm_d;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        use_rs1, use_rs2, writes_rd;
  logic [63:0] imm;
  logic        hazard;
  logic        set_busy;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    imm       = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        writes_rd = 1'b1;
        imm       = {{32{instr_q[31]}}, instr_q[31:12], 12'b0};
      end
      OPC_JAL: begin
        writes_rd = 1'b1;
        imm       = {{44{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        imm       = {{52{instr_q[31]}}, instr_q[31:20]};
      end
      OPC_OP, OPC_OP_32: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{52{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      end
      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{52{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      end
      // FENCE/SYSTEM carry an I-format immediate but touch no scoreboarded registers
      OPC_FENCE, OPC_SYSTEM: begin
        imm = {{52{instr_q[31]}}, instr_q[31:20]};
      end
      default: ;
    endcase
  end

  // busy[0] is held at 0, so rd=x0 or rs=x0 never causes a stall
  assign hazard = (use_rs1 && busy_q[rs1]) || (use_rs2 && busy_q[rs2]) ||
                  (writes_rd && busy_q[rd]);

  always_comb begin
    state_d           = state_q;
    instr_d           = instr_q;
    pc_d              = pc_q;
    busy_d            = busy_q;
    ex_pc_d           = ex_pc_q;
    ex_opcode_d       = ex_opcode_q;
    ex_funct3_d       = ex_funct3_q;
    ex_funct7_d       = ex_funct7_q;
    ex_rd_d           = ex_rd_q;
    ex_rs1_data_d     = ex_rs1_data_q;
    ex_rs2_data_d     = ex_rs2_data_q;
    ex_imm_d          = ex_imm_q;
    ofetch_ready      = 1'b0;
    oex_valid         = 1'b0;
    orf_read_reg_num0 = '0;
    orf_read_reg_num1 = '0;
    set_busy          = 1'b0;

    case (state_q)
      S_IDLE: begin
        ofetch_ready = reset_n;
        if (ifetch_valid) begin
          instr_d = ifetch_instr;
          pc_d    = ifetch_pc;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        orf_read_reg_num0 = use_rs1 ? rs1 : '0;
        orf_read_reg_num1 = use_rs2 ? rs2 : '0;
        if (iflush)       state_d = S_IDLE;
        else if (!hazard) state_d = S_READ;
      end
      S_READ: begin
        orf_read_reg_num0 = use_rs1 ? rs1 : '0;
        orf_read_reg_num1 = use_rs2 ? rs2 : '0;
        if (iflush) begin
          state_d = S_IDLE;
        end else begin
          ex_pc_d       = pc_q;
          ex_opcode_d   = opcode;
          ex_funct3_d   = instr_q[14:12];
          ex_funct7_d   = instr_q[31:25];
          ex_rd_d       = rd;
          ex_rs1_data_d = irf_read_data0;
          ex_rs2_data_d = irf_read_data1;
          ex_imm_d      = imm;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        oex_valid = 1'b1;
        if (iex_ready) begin
          set_busy = writes_rd;
          state_d  = S_IDLE;
        end else if (iflush) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // clear before set so an issuing rd stays busy on a coincident writeback
    if (iwb_valid) busy_d[iwb_reg_num] = 1'b0;
    if (set_busy)  busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      pc_q          <= '0;
      busy_q        <= '0;
      ex_pc_q       <= '0;
      ex_opcode_q   <= '0;
      ex_funct3_q   <= '0;
      ex_funct7_q   <= '0;
      ex_rd_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      busy_q        <= busy_d;
      ex_pc_q       <= ex_pc_d;
      ex_opcode_q   <= ex_opcode_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7_q   <= ex_funct7_d;
      ex_rd_q       <= ex_rd_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
    end
  end

  assign oex_pc       = ex_pc_q;
  assign oex_opcode   = ex_opcode_q;
  assign oex_funct3   = ex_funct3_q;
  assign oex_funct7   = ex_funct7_q;
  assign oex_rd       = ex_rd_q;
  assign oex_rs1_data = ex_rs1_data_q;
  assign oex_rs2_data = ex_rs2_data_q;
  assign oex_imm      = ex_imm_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed hazard/flush/reset scenarios plus random instruction
// streams, checked against a transaction-level decode and scoreboard model.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifetch_valid;
  logic [31:0] ifetch_instr;
  logic [63:0] ifetch_pc;
  logic        ofetch_ready;
  logic [4:0]  orf_read_reg_num0, orf_read_reg_num1;
  logic [63:0] irf_read_data0, irf_read_data1;
  logic        iwb_valid;
  logic [4:0]  iwb_reg_num;
  logic        iflush;
  logic        oex_valid;
  logic        iex_ready;
  logic [63:0] oex_pc;
  logic [6:0]  oex_opcode;
  logic [2:0]  oex_funct3;
  logic [6:0]  oex_funct7;
  logic [4:0]  oex_rd;
  logic [63:0] oex_rs1_data, oex_rs2_data, oex_imm;

  decode_issue dut (
    .clk(clk), .reset_n(reset_n),
    .ifetch_valid(ifetch_valid), .ifetch_instr(ifetch_instr), .ifetch_pc(ifetch_pc),
    .ofetch_ready(ofetch_ready),
    .orf_read_reg_num0(orf_read_reg_num0), .orf_read_reg_num1(orf_read_reg_num1),
    .irf_read_data0(irf_read_data0), .irf_read_data1(irf_read_data1),
    .iwb_valid(iwb_valid), .iwb_reg_num(iwb_reg_num), .iflush(iflush),
    .oex_valid(oex_valid), .iex_ready(iex_ready),
    .oex_pc(oex_pc), .oex_opcode(oex_opcode), .oex_funct3(oex_funct3),
    .oex_funct7(oex_funct7), .oex_rd(oex_rd),
    .oex_rs1_data(oex_rs1_data), .oex_rs2_data(oex_rs2_data), .oex_imm(oex_imm)
  );

  always #5 clk = ~clk;

  // Register file model: one-cycle registered read, write on the writeback edge
  logic [63:0] rf [32];
  logic [63:0] wb_data;
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= (i == 0) ? 64'h0 : {32'(32'hA5A5_0000 + i), 32'(i * 7 + 3)};
    end else if (iwb_valid && iwb_reg_num != 5'd0) begin
      rf[iwb_reg_num] <= wb_data;
    end
    irf_read_data0 <= (orf_read_reg_num0 == 5'd0) ? 64'h0 : rf[orf_read_reg_num0];
    irf_read_data1 <= (orf_read_reg_num1 == 5'd0) ? 64'h0 : rf[orf_read_reg_num1];
  end

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        us1;
    logic        us2;
    logic        wr;
    logic [63:0] imm;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] busy_m  = '0;
  logic        cur_wr  = 1'b0;
  logic [4:0]  cur_rd  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [63:0] pc);
    exp_t e;
    e        = '0;
    e.pc     = pc;
    e.opcode = i[6:0];
    e.f3     = i[14:12];
    e.f7     = i[31:25];
    e.rd     = i[11:7];
    e.rs1    = i[19:15];
    e.rs2    = i[24:20];
    case (i[6:0])
      7'h37, 7'h17: begin e.wr = 1; e.imm = 64'($signed(i[31:12])) * 4096; end
      7'h6F: begin
        e.wr  = 1;
        e.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h67, 7'h03, 7'h13, 7'h1B: begin
        e.us1 = 1; e.wr = 1; e.imm = 64'($signed(i[31:20]));
      end
      7'h33, 7'h3B: begin e.us1 = 1; e.us2 = 1; e.wr = 1; end
      7'h63: begin
        e.us1 = 1; e.us2 = 1;
        e.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h23: begin e.us1 = 1; e.us2 = 1; e.imm = 64'($signed({i[31:25], i[11:7]})); end
      7'h0F, 7'h73: e.imm = 64'($signed(i[31:20]));
      default: ;
    endcase
    return e;
  endfunction

  // Advance one clock and apply the scoreboard rules to the model
  task automatic tick();
    logic hs;
    hs = oex_valid && iex_ready;
    @(posedge clk);
    if (!reset_n) busy_m = '0;
    else begin
      if (iwb_valid) busy_m[iwb_reg_num] = 1'b0;
      if (hs && cur_wr) busy_m[cur_rd] = 1'b1;
      busy_m[0] = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic drive_wb(input int r, input logic [63:0] v);
    iwb_valid   = 1'b1;
    iwb_reg_num = 5'(r);
    wb_data     = v;
  endtask

  task automatic rand_wb();
    int s;
    s = $urandom_range(0, 31);
    for (int j = 0; j < 32; j++)
      if (busy_m[(s + j) % 32]) begin
        drive_wb((s + j) % 32, {$urandom, $urandom});
        break;
      end
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [63:0] pc, input int hold,
                           input bit rnd, input int f_reg, input int f_dly,
                           input logic [63:0] f_val, input int hs_reg);
    exp_t        e;
    int          a, w_last, t;
    logic [31:0] need;
    logic [63:0] d1, d2;
    t = 0;
    while (!ofetch_ready && t < 50) begin tick(); t++; end
    check("fetch_ready", 64'(ofetch_ready), 64'd1);
    e    = ref_decode(ins, pc);
    need = '0;
    if (e.us1) need[e.rs1] = busy_m[e.rs1];
    if (e.us2) need[e.rs2] = busy_m[e.rs2];
    if (e.wr)  need[e.rd]  = busy_m[e.rd];
    need[0] = 1'b0;
    cur_wr  = e.wr && (e.rd != 5'd0);
    cur_rd  = e.rd;
    ifetch_valid = 1'b1; ifetch_instr = ins; ifetch_pc = pc;
    a = cyc;
    tick();
    ifetch_valid = 1'b0;
    w_last = a;
    t = 0;
    while (!oex_valid && t < 300) begin
      check("rf_addr0", 64'(orf_read_reg_num0), e.us1 ? 64'(e.rs1) : 64'd0);
      check("rf_addr1", 64'(orf_read_reg_num1), e.us2 ? 64'(e.rs2) : 64'd0);
      check("stall_ready", 64'(ofetch_ready), 64'd0);
      if (f_reg >= 0 && cyc == a + f_dly) drive_wb(f_reg, f_val);
      else if (rnd && $urandom_range(0, 1) == 0) rand_wb();
      if (iwb_valid && need[iwb_reg_num]) begin
        need[iwb_reg_num] = 1'b0;
        if (need == '0) w_last = cyc;
      end
      tick();
      iwb_valid = 1'b0;
      t++;
    end
    check("latency", 64'(cyc), 64'((w_last + 3 > a + 3) ? w_last + 3 : a + 3));
    if (!oex_valid) begin
      check("issue_valid", 64'(oex_valid), 64'd1);
      return;
    end
    d1 = e.us1 ? rf[e.rs1] : 64'h0;
    d2 = e.us2 ? rf[e.rs2] : 64'h0;
    for (int k = 0; k <= hold; k++) begin
      check("oex_valid", 64'(oex_valid), 64'd1);
      check("issue_ready", 64'(ofetch_ready), 64'd0);
      check("oex_pc", oex_pc, e.pc);
      check("oex_opcode", 64'(oex_opcode), 64'(e.opcode));
      check("oex_funct3", 64'(oex_funct3), 64'(e.f3));
      check("oex_funct7", 64'(oex_funct7), 64'(e.f7));
      check("oex_rd", 64'(oex_rd), 64'(e.rd));
      check("oex_rs1_data", oex_rs1_data, d1);
      check("oex_rs2_data", oex_rs2_data, d2);
      check("oex_imm", oex_imm, e.imm);
      iex_ready = (k == hold);
      if (k == hold && hs_reg >= 0) drive_wb(hs_reg, f_val);
      else if (rnd && $urandom_range(0, 1) == 0) rand_wb();
      tick();
      iex_ready = 1'b0;
      iwb_valid = 1'b0;
    end
    check("post_issue_valid", 64'(oex_valid), 64'd0);
  endtask

  logic [6:0] ops [14] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                           7'h13, 7'h1B, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h7F};

  initial begin
    logic [31:0] r;
    reset_n = 1'b0; ifetch_valid = 1'b0; ifetch_instr = '0; ifetch_pc = '0;
    iwb_valid = 1'b0; iwb_reg_num = '0; wb_data = '0; iflush = 1'b0; iex_ready = 1'b0;
    tick(); tick();
    check("rst_fetch_ready", 64'(ofetch_ready), 64'd0);
    check("rst_oex_valid", 64'(oex_valid), 64'd0);
    check("rst_oex_pc", oex_pc, 64'd0);
    check("rst_oex_imm", oex_imm, 64'd0);
    check("rst_oex_rs1", oex_rs1_data, 64'd0);
    check("rst_rf_addr", 64'({orf_read_reg_num0, orf_read_reg_num1}), 64'd0);
    reset_n = 1'b1;
    tick();
    check("release_ready", 64'(ofetch_ready), 64'd1);

    // basic issue, RAW on x1, backpressure, immediates
    run_instr(32'h0050_0093, 64'h1000, 0, 0, -1, 0, 64'h0, -1);
    run_instr(32'h0010_8133, 64'h1004, 0, 0, 1, 4, 64'd5, -1);
    run_instr(32'hFFF0_0413, 64'h1008, 5, 0, -1, 0, 64'h0, -1);
    run_instr(32'hFE00_0EE3, 64'h100C, 0, 0, -1, 0, 64'h0, -1);
    run_instr(32'h8000_01B7, 64'h1010, 1, 0, -1, 0, 64'h0, -1);

    // WAW on x5, then writeback/set collision keeps x5 busy
    run_instr(32'h0070_0293, 64'h1014, 0, 0, -1, 0, 64'h0, -1);
    run_instr(32'h0010_0293, 64'h1018, 0, 0, 5, 5, 64'h55, 5);
    run_instr(32'h0002_8313, 64'h101C, 0, 0, 5, 6, 64'h66, -1);

    // flush while in READ
    cur_wr = 1'b0;
    ifetch_valid = 1'b1; ifetch_instr = 32'h0090_0493; ifetch_pc = 64'h2000;
    tick();
    ifetch_valid = 1'b0;
    tick();
    iflush = 1'b1;
    tick();
    iflush = 1'b0;
    check("flush_valid", 64'(oex_valid), 64'd0);
    check("flush_idle", 64'(ofetch_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_no_issue", 64'(oex_valid), 64'd0);
    end
    run_instr(32'h0004_8513, 64'h2004, 0, 0, -1, 0, 64'h0, -1);

    // reset while in ISSUE clears the scoreboard
    cur_wr = 1'b0;
    ifetch_valid = 1'b1; ifetch_instr = 32'h0010_0593; ifetch_pc = 64'h3000;
    tick();
    ifetch_valid = 1'b0;
    tick(); tick();
    check("pre_reset_valid", 64'(oex_valid), 64'd1);
    reset_n = 1'b0;
    tick();
    check("mid_reset_valid", 64'(oex_valid), 64'd0);
    check("mid_reset_imm", oex_imm, 64'd0);
    check("mid_reset_pc", oex_pc, 64'd0);
    check("mid_reset_ready", 64'(ofetch_ready), 64'd0);
    reset_n = 1'b1;
    tick();
    run_instr(32'h0031_0633, 64'h3004, 0, 0, -1, 0, 64'h0, -1);

    // random instruction stream with random writebacks and backpressure
    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 13)];
      run_instr(r, {$urandom, $urandom} & ~64'h3, $urandom_range(0, 3), 1, -1, 0, 64'h0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
